// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: state encoding and
// default reset/trap vectors.
package pc_seq_pkg;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  typedef enum logic [1:0] {
    BOOT  = S_BOOT,
    RUN   = S_RUN,
    FAULT = S_FAULT
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-request and control-flow signals between the PC sequencer (master)
// and the fetch/branch/trap logic around it (slave).
interface pc_sequencer_if #(
  parameter int XLEN = 32
);

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap;
  logic            misalign;
  logic [XLEN-1:0] fault_addr;
  logic [31:0]     fetch_count;

  modport master (
    output fetch_valid, fetch_pc, misalign, fault_addr, fetch_count,
    input  fetch_ready, redirect_valid, redirect_pc, trap
  );

  modport slave (
    input  fetch_valid, fetch_pc, misalign, fault_addr, fetch_count,
    output fetch_ready, redirect_valid, redirect_pc, trap
  );

endinterface

// File: rtl/pc_incrementer.sv
// Combinational sequential-PC adder; the sum wraps modulo 2^XLEN.
module pc_incrementer #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o
);

  assign pc_next_o = pc_i + XLEN'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the architectural PC, offers it to fetch
// and applies trap > redirect > accept on each edge.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              STEP       = 4,
  parameter int              ALIGN_BITS = 2,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEFAULT_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEFAULT_TRAP_VEC)
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_step;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     count_q, count_d;
  logic            accept;
  logic            target_aligned;

  pc_incrementer #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_incr (
    .pc_i      (pc_q),
    .pc_next_o (pc_step)
  );

  assign accept         = (state_q == RUN) && bus.fetch_ready;
  assign target_aligned = (bus.redirect_pc[ALIGN_BITS-1:0] == '0);

  // NOTE: every signal gets its hold value first so no branch can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    misalign_d   = misalign_q;
    count_d      = count_q;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.trap) begin
          pc_d       = TRAP_VEC;
          misalign_d = 1'b0;
        end else begin
          // The fetch of the old PC completes even when a redirect replaces it.
          if (accept) count_d = count_q + 32'd1;
          if (bus.redirect_valid) begin
            if (target_aligned) begin
              pc_d = bus.redirect_pc;
            end else begin
              state_d      = FAULT;
              misalign_d   = 1'b1;
              fault_addr_d = bus.redirect_pc;
            end
          end else if (accept) begin
            pc_d = pc_step;
          end
        end
      end
      FAULT: begin
        if (bus.trap) begin
          state_d    = RUN;
          pc_d       = TRAP_VEC;
          misalign_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      fault_addr_q <= '0;
      misalign_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      misalign_q   <= misalign_d;
      count_q      <= count_d;
    end
  end

  assign bus.fetch_valid = (state_q == RUN);
  assign bus.fetch_pc    = pc_q;
  assign bus.misalign    = misalign_q;
  assign bus.fault_addr  = fault_addr_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized traffic
// checked against a behavioural model of the sequencer.
module tb_pc_sequencer;

  localparam int          XLEN       = 32;
  localparam int          STEP       = 4;
  localparam int          ALIGN_BITS = 2;
  localparam logic [31:0] RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC   = 32'h0000_0100;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_sequencer_if #(.XLEN(XLEN)) bus ();

  pc_sequencer #(
    .XLEN       (XLEN),
    .STEP       (STEP),
    .ALIGN_BITS (ALIGN_BITS),
    .RESET_VEC  (RESET_VEC),
    .TRAP_VEC   (TRAP_VEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: booting / faulted flags plus architectural values.
  logic        m_boot;
  logic        m_fault;
  logic        m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_faddr;

  task automatic drive(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic tp);
    rst                = r;
    bus.fetch_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.trap           = tp;
    @(posedge clk);
    if (r) begin
      m_boot = 1'b1; m_fault = 1'b0; m_mis = 1'b0;
      m_pc = RESET_VEC; m_cnt = 0; m_faddr = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (tp) begin
      m_pc = TRAP_VEC; m_fault = 1'b0; m_mis = 1'b0;
    end else if (!m_fault) begin
      if (rdy) m_cnt = m_cnt + 1;
      if (rv) begin
        if (rpc % (1 << ALIGN_BITS) == 0) m_pc = rpc;
        else begin
          m_fault = 1'b1; m_mis = 1'b1; m_faddr = rpc;
        end
      end else if (rdy) begin
        m_pc = m_pc + STEP;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 32'h40, 1);
    total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.fetch_valid); end
    total++; if (bus.fetch_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", bus.fetch_pc); end
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", bus.misalign); end
    total++; if (bus.fault_addr !== 32'h0) begin bad++; $display("FAIL reset_fault_addr: got %h want 0", bus.fault_addr); end
    total++; if (bus.fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.fetch_count); end
  endtask

  task automatic test_sequential();
    drive(0, 1, 0, 0, 0);
    total++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h0) begin bad++; $display("FAIL seq_first: got valid=%b pc=%h want valid=1 pc=0", bus.fetch_valid, bus.fetch_pc); end
    total++; if (bus.fetch_count !== 32'd0) begin bad++; $display("FAIL seq_boot_count: got %0d want 0", bus.fetch_count); end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 0, 0);
      total++; if (bus.fetch_pc !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.fetch_pc, 32'(4 * i)); end
    end
    total++; if (bus.fetch_count !== 32'd3) begin bad++; $display("FAIL seq_count: got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_stall();
    drive(0, 1, 0, 0, 0);
    total++; if (bus.fetch_pc !== 32'h10) begin bad++; $display("FAIL stall_start: got %h want 10", bus.fetch_pc); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      total++; if (bus.fetch_pc !== 32'h10 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d: got pc=%h valid=%b want pc=10 valid=1", i, bus.fetch_pc, bus.fetch_valid); end
    end
    drive(0, 1, 0, 0, 0);
    total++; if (bus.fetch_pc !== 32'h14) begin bad++; $display("FAIL stall_release: got %h want 14", bus.fetch_pc); end
    total++; if (bus.fetch_count !== 32'd5) begin bad++; $display("FAIL stall_count: got %0d want 5", bus.fetch_count); end
  endtask

  task automatic test_redirect_accept();
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
    total++; if (bus.fetch_pc !== 32'h20) begin bad++; $display("FAIL redir_setup: got %h want 20", bus.fetch_pc); end
    drive(0, 1, 1, 32'h200, 0);
    total++; if (bus.fetch_pc !== 32'h200) begin bad++; $display("FAIL redir_pc: got %h want 200", bus.fetch_pc); end
    total++; if (bus.fetch_count !== 32'd9) begin bad++; $display("FAIL redir_count: got %0d want 9", bus.fetch_count); end
  endtask

  task automatic test_misalign();
    drive(0, 0, 1, 32'h202, 0);
    total++; if (bus.misalign !== 1'b1 || bus.fault_addr !== 32'h202 || bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL mis_enter: got mis=%b addr=%h valid=%b want 1/202/0", bus.misalign, bus.fault_addr, bus.fetch_valid); end
    drive(0, 1, 1, 32'h300, 0);
    total++; if (bus.misalign !== 1'b1 || bus.fault_addr !== 32'h202 || bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL mis_ignore: got mis=%b addr=%h valid=%b want 1/202/0", bus.misalign, bus.fault_addr, bus.fetch_valid); end
    total++; if (bus.fetch_pc !== 32'h200 || bus.fetch_count !== 32'd9) begin bad++; $display("FAIL mis_hold: got pc=%h cnt=%0d want pc=200 cnt=9", bus.fetch_pc, bus.fetch_count); end
    drive(0, 0, 0, 0, 1);
    total++; if (bus.fetch_pc !== 32'h100 || bus.misalign !== 1'b0 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL mis_trap: got pc=%h mis=%b valid=%b want 100/0/1", bus.fetch_pc, bus.misalign, bus.fetch_valid); end
  endtask

  task automatic test_trap_priority();
    drive(0, 1, 0, 0, 0);
    total++; if (bus.fetch_pc !== 32'h104) begin bad++; $display("FAIL prio_setup: got %h want 104", bus.fetch_pc); end
    drive(0, 0, 1, 32'h400, 1);
    total++; if (bus.fetch_pc !== 32'h100) begin bad++; $display("FAIL prio_pc: got %h want 100", bus.fetch_pc); end
    total++; if (bus.fetch_count !== 32'd10) begin bad++; $display("FAIL prio_count: got %0d want 10", bus.fetch_count); end
  endtask

  task automatic test_wrap_and_reset();
    drive(0, 0, 1, 32'hFFFF_FFFC, 0);
    total++; if (bus.fetch_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup: got %h want fffffffc", bus.fetch_pc); end
    drive(0, 1, 0, 0, 0);
    total++; if (bus.fetch_pc !== 32'h0 || bus.misalign !== 1'b0 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc: got pc=%h mis=%b valid=%b want 0/0/1", bus.fetch_pc, bus.misalign, bus.fetch_valid); end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    total++; if (bus.fetch_pc !== 32'h4 || bus.fetch_count !== 32'd12) begin bad++; $display("FAIL wrap_stall: got pc=%h cnt=%0d want 4/12", bus.fetch_pc, bus.fetch_count); end
    drive(1, 0, 0, 0, 0);
    total++; if (bus.fetch_valid !== 1'b0 || bus.fetch_pc !== 32'h0 || bus.fetch_count !== 32'd0) begin bad++; $display("FAIL rst_stall: got valid=%b pc=%h cnt=%0d want 0/0/0", bus.fetch_valid, bus.fetch_pc, bus.fetch_count); end
    drive(0, 1, 0, 0, 0);
    total++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h0 || bus.fetch_count !== 32'd0) begin bad++; $display("FAIL rst_resume: got valid=%b pc=%h cnt=%0d want 1/0/0", bus.fetch_valid, bus.fetch_pc, bus.fetch_count); end
  endtask

  task automatic test_random();
    logic        r, rdy, rv, tp, exp_valid;
    logic [31:0] rpc;
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      tp  = ($urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 3) == 0);
      rdy = tp ? 1'b0 : ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom & 32'hFFFF_FFFC;
        1:       rpc = 32'hFFFF_FFF8;
        2:       rpc = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
        default: rpc = $urandom & 32'h0000_FFFC;
      endcase
      drive(r, rdy, rv, rpc, tp);
      exp_valid = !m_boot && !m_fault;
      total++;
      if (bus.fetch_valid !== exp_valid || bus.fetch_pc !== m_pc ||
          bus.misalign !== m_mis || bus.fetch_count !== m_cnt ||
          (m_mis && bus.fault_addr !== m_faddr)) begin
        bad++;
        $display("FAIL rand%0d: got valid=%b pc=%h mis=%b cnt=%0d addr=%h want valid=%b pc=%h mis=%b cnt=%0d addr=%h",
                 n, bus.fetch_valid, bus.fetch_pc, bus.misalign, bus.fetch_count, bus.fault_addr,
                 exp_valid, m_pc, m_mis, m_cnt, m_faddr);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_accept();
    test_misalign();
    test_trap_priority();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
